// File: rtl/ad9911_sweep_sched.sv
`default_nettype none
// ============================================================================
//  Module      : ad9911_sweep_sched
//  Description : Frequency-sweep scheduler for the AD9911 CTW0 update path.
//                Walks a tuning word from a captured base in fixed steps,
//                issuing one FREQW/FREQW_UPDATE request per point to the
//                AD9911 update controller, waiting for FREQW_UPDATE_OVER and
//                holding each point for a programmable dwell.
//
//  Ports
//    CLK, RESET           : system clock, asynchronous active-high reset
//    START, ABORT         : one-cycle sweep start / stop requests
//    MODE                 : 0 single sweep, 1 continuous repeat
//    BASE_FREQW           : tuning word of point 0
//    STEP_FREQW           : per-point increment (mod 2^32)
//    STEP_NUM             : index of the last point
//    DWELL                : hold cycles per acknowledged point (0 acts as 1)
//    INIT_OK              : AD9911 init-complete flag
//    FREQW_UPDATE_OVER    : update-done flag from the update controller
//    FREQW, FREQW_UPDATE  : request to the update controller
//    BUSY                 : scheduler not idle
//    STEP_IDX, STEP_TICK  : live point index / new-point pulse
//    SWEEP_DONE           : pulse after the last point's dwell
//    TIMEOUT_ERR          : sticky acknowledge-timeout flag
//
//  Revision    : 1.0  initial release
// ============================================================================
module ad9911_sweep_sched #(
  parameter int IDX_W   = 16,
  parameter int DWELL_W = 24,
  parameter int TO_W    = 16
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               START,
  input  logic               ABORT,
  input  logic               MODE,
  input  logic [31:0]        BASE_FREQW,
  input  logic [31:0]        STEP_FREQW,
  input  logic [IDX_W-1:0]   STEP_NUM,
  input  logic [DWELL_W-1:0] DWELL,
  input  logic               INIT_OK,
  input  logic               FREQW_UPDATE_OVER,
  output logic [31:0]        FREQW,
  output logic               FREQW_UPDATE,
  output logic               BUSY,
  output logic [IDX_W-1:0]   STEP_IDX,
  output logic               STEP_TICK,
  output logic               SWEEP_DONE,
  output logic               TIMEOUT_ERR
);

  localparam logic [2:0] c_IDLE      = 3'd0;
  localparam logic [2:0] c_WAIT_INIT = 3'd1;
  localparam logic [2:0] c_REQ       = 3'd2;
  localparam logic [2:0] c_GUARD     = 3'd3;
  localparam logic [2:0] c_WAIT_ACK  = 3'd4;
  localparam logic [2:0] c_DWELL     = 3'd5;
  localparam logic [2:0] c_DRAIN     = 3'd6;

  localparam logic [TO_W-1:0] c_TO_LAST = {TO_W{1'b1}};

  // FSM state
  logic [2:0]         r_state;
  logic [2:0]         w_state_nxt;

  // Captured sweep settings
  logic               r_mode;
  logic [31:0]        r_base;
  logic [31:0]        r_step;
  logic [IDX_W-1:0]   r_last_idx;
  logic [DWELL_W-1:0] r_dwell_len;

  // Sweep datapath
  logic [31:0]        r_acc;
  logic [IDX_W-1:0]   r_idx;
  logic [DWELL_W-1:0] r_dwell_cnt;
  logic [TO_W-1:0]    r_to_cnt;
  logic               r_guard_cnt;

  // Registered outputs
  logic [31:0]        r_freqw;
  logic               r_freqw_update;
  logic               r_busy;
  logic [IDX_W-1:0]   r_step_idx;
  logic               r_step_tick;
  logic               r_sweep_done;
  logic               r_timeout_err;

  // Combinational helpers and next values
  logic               w_last;
  logic               w_to_last;
  logic               w_dwell_exp;
  logic               w_start_acc;
  logic               w_tick;
  logic               w_to_set;
  logic [31:0]        w_acc_nxt;
  logic [IDX_W-1:0]   w_idx_nxt;
  logic [31:0]        w_freqw_nxt;
  logic               w_freqw_update_nxt;
  logic               w_busy_nxt;
  logic [IDX_W-1:0]   w_step_idx_nxt;
  logic               w_sweep_done_nxt;
  logic               w_timeout_err_nxt;

  assign w_last      = (r_idx == r_last_idx);
  assign w_to_last   = (r_to_cnt == c_TO_LAST);
  // The dwell counter is loaded with max(DWELL,1) and counts down to zero;
  // the zero cycle is the extra advance cycle of the point period.
  assign w_dwell_exp = (r_dwell_cnt == '0);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE: begin
        if (START && !ABORT) w_state_nxt = c_WAIT_INIT;
      end
      c_WAIT_INIT: begin
        if (ABORT)        w_state_nxt = c_IDLE;
        else if (INIT_OK) w_state_nxt = c_REQ;
      end
      c_REQ: begin
        // The request is already on the wire, so an abort must drain it.
        if (ABORT) w_state_nxt = c_DRAIN;
        else       w_state_nxt = c_GUARD;
      end
      c_GUARD: begin
        // UPDATE_OVER is stale here until the controller samples the request.
        if (ABORT)            w_state_nxt = c_DRAIN;
        else if (r_guard_cnt) w_state_nxt = c_WAIT_ACK;
      end
      c_WAIT_ACK: begin
        if (ABORT)                  w_state_nxt = c_DRAIN;
        else if (FREQW_UPDATE_OVER) w_state_nxt = c_DWELL;
        else if (w_to_last)         w_state_nxt = c_IDLE;
      end
      c_DWELL: begin
        if (ABORT) begin
          w_state_nxt = c_IDLE;
        end else if (w_dwell_exp) begin
          if (w_last && !r_mode) w_state_nxt = c_IDLE;
          else                   w_state_nxt = c_REQ;
        end
      end
      c_DRAIN: begin
        if (FREQW_UPDATE_OVER || w_to_last) w_state_nxt = c_IDLE;
      end
      default: w_state_nxt = c_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Output / datapath next-value logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_start_acc = (r_state == c_IDLE) && (w_state_nxt == c_WAIT_INIT);
    w_tick      = (r_state == c_WAIT_ACK) && (w_state_nxt == c_DWELL);
    w_to_set    = ((r_state == c_WAIT_ACK) && (w_state_nxt == c_IDLE)) ||
                  ((r_state == c_DRAIN) && !FREQW_UPDATE_OVER && w_to_last);

    w_acc_nxt = r_acc;
    w_idx_nxt = r_idx;
    if ((r_state == c_WAIT_INIT) && (w_state_nxt == c_REQ)) begin
      w_acc_nxt = r_base;
      w_idx_nxt = '0;
    end else if ((r_state == c_DWELL) && (w_state_nxt == c_REQ)) begin
      if (w_last) begin
        w_acc_nxt = r_base;
        w_idx_nxt = '0;
      end else begin
        w_acc_nxt = r_acc + r_step;
        w_idx_nxt = r_idx + IDX_W'(1);
      end
    end

    w_freqw_update_nxt = (w_state_nxt == c_REQ);
    w_freqw_nxt        = w_freqw_update_nxt ? w_acc_nxt : r_freqw;
    w_busy_nxt         = (w_state_nxt != c_IDLE);
    w_step_idx_nxt     = w_tick ? r_idx : r_step_idx;
    // Registered one cycle ahead so the pulse coincides with the expiry cycle.
    w_sweep_done_nxt   = (r_state == c_DWELL) && !ABORT && w_last &&
                         (r_dwell_cnt == DWELL_W'(1));
    if (w_start_acc)   w_timeout_err_nxt = 1'b0;
    else               w_timeout_err_nxt = r_timeout_err | w_to_set;
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_mode      <= 1'b0;
      r_base      <= '0;
      r_step      <= '0;
      r_last_idx  <= '0;
      r_dwell_len <= '0;
      r_acc       <= '0;
      r_idx       <= '0;
      r_dwell_cnt <= '0;
      r_to_cnt    <= '0;
      r_guard_cnt <= 1'b0;
    end else begin
      if (w_start_acc) begin
        r_mode      <= MODE;
        r_base      <= BASE_FREQW;
        r_step      <= STEP_FREQW;
        r_last_idx  <= STEP_NUM;
        r_dwell_len <= (DWELL == '0) ? DWELL_W'(1) : DWELL;
      end
      r_acc <= w_acc_nxt;
      r_idx <= w_idx_nxt;

      if (w_tick) begin
        r_dwell_cnt <= r_dwell_len;
      end else if ((r_state == c_DWELL) && !w_dwell_exp) begin
        r_dwell_cnt <= r_dwell_cnt - DWELL_W'(1);
      end

      // Timeout counter restarts on every entry to WAIT_ACK or DRAIN.
      if (((r_state == c_WAIT_ACK) || (r_state == c_DRAIN)) &&
          (w_state_nxt == r_state)) begin
        r_to_cnt <= r_to_cnt + TO_W'(1);
      end else begin
        r_to_cnt <= '0;
      end

      r_guard_cnt <= (r_state == c_GUARD) ? ~r_guard_cnt : 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Output registers
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_freqw        <= '0;
      r_freqw_update <= 1'b0;
      r_busy         <= 1'b0;
      r_step_idx     <= '0;
      r_step_tick    <= 1'b0;
      r_sweep_done   <= 1'b0;
      r_timeout_err  <= 1'b0;
    end else begin
      r_freqw        <= w_freqw_nxt;
      r_freqw_update <= w_freqw_update_nxt;
      r_busy         <= w_busy_nxt;
      r_step_idx     <= w_step_idx_nxt;
      r_step_tick    <= w_tick;
      r_sweep_done   <= w_sweep_done_nxt;
      r_timeout_err  <= w_timeout_err_nxt;
    end
  end

  assign FREQW        = r_freqw;
  assign FREQW_UPDATE = r_freqw_update;
  assign BUSY         = r_busy;
  assign STEP_IDX     = r_step_idx;
  assign STEP_TICK    = r_step_tick;
  assign SWEEP_DONE   = r_sweep_done;
  assign TIMEOUT_ERR  = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_ad9911_sweep_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ad9911_sweep_sched
//  Description : Self-checking bench for ad9911_sweep_sched with a simple
//                AD9911 update-controller model and a FREQW/STEP_IDX
//                scoreboard.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ad9911_sweep_sched;

  localparam int IDX_W   = 16;
  localparam int DWELL_W = 24;
  localparam int TO_W    = 6;

  logic               CLK = 1'b0;
  logic               RESET;
  logic               START, ABORT, MODE, INIT_OK;
  logic [31:0]        BASE_FREQW, STEP_FREQW;
  logic [IDX_W-1:0]   STEP_NUM;
  logic [DWELL_W-1:0] DWELL;
  logic               FREQW_UPDATE_OVER;
  logic [31:0]        FREQW;
  logic               FREQW_UPDATE, BUSY, STEP_TICK, SWEEP_DONE, TIMEOUT_ERR;
  logic [IDX_W-1:0]   STEP_IDX;

  ad9911_sweep_sched #(.IDX_W(IDX_W), .DWELL_W(DWELL_W), .TO_W(TO_W)) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .ABORT(ABORT), .MODE(MODE),
    .BASE_FREQW(BASE_FREQW), .STEP_FREQW(STEP_FREQW), .STEP_NUM(STEP_NUM),
    .DWELL(DWELL), .INIT_OK(INIT_OK), .FREQW_UPDATE_OVER(FREQW_UPDATE_OVER),
    .FREQW(FREQW), .FREQW_UPDATE(FREQW_UPDATE), .BUSY(BUSY),
    .STEP_IDX(STEP_IDX), .STEP_TICK(STEP_TICK), .SWEEP_DONE(SWEEP_DONE),
    .TIMEOUT_ERR(TIMEOUT_ERR)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int ack_lat = 4;         // 0 = controller never acknowledges
  int ack_cnt = 0;
  int tick_cnt, done_cnt, last_done_tick, tpd, exp_period, last_req_cyc;
  logic prev_upd = 1'b0;
  logic [31:0]      exp_fw[$];
  logic [IDX_W-1:0] exp_idx[$];

  always @(posedge CLK) cyc <= cyc + 1;

  // Update-controller model: clears OVER when it samples a request and
  // raises it ack_lat edges later, holding it until the next request.
  always @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      FREQW_UPDATE_OVER <= 1'b0;
      ack_cnt <= 0;
    end else if (FREQW_UPDATE) begin
      FREQW_UPDATE_OVER <= 1'b0;
      ack_cnt <= ack_lat;
    end else if (ack_cnt != 0) begin
      if (ack_cnt == 1) FREQW_UPDATE_OVER <= 1'b1;
      ack_cnt <= ack_cnt - 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor
  always @(negedge CLK) begin
    if (!RESET) begin
      if (FREQW_UPDATE) begin
        chk("upd_one_cycle", {31'd0, prev_upd}, 32'd0);
        if (exp_period != 0 && last_req_cyc >= 0)
          chk("req_period", 32'(cyc - last_req_cyc), 32'(exp_period));
        last_req_cyc = cyc;
        checks++;
        assert (exp_fw.size() != 0) else begin
          failures++;
          $error("FAIL unexpected_req observed=0x%0h expected=no_request", FREQW);
        end
        if (exp_fw.size() != 0) chk("freqw", FREQW, exp_fw.pop_front());
      end
      if (STEP_TICK) begin
        tick_cnt++;
        checks++;
        assert (exp_idx.size() != 0) else begin
          failures++;
          $error("FAIL unexpected_tick observed=%0d expected=no_tick", STEP_IDX);
        end
        if (exp_idx.size() != 0) chk("step_idx", 32'(STEP_IDX), 32'(exp_idx.pop_front()));
      end
      if (SWEEP_DONE) begin
        done_cnt++;
        chk("done_spacing", 32'(tick_cnt - last_done_tick), 32'(tpd));
        last_done_tick = tick_cnt;
      end
      prev_upd = FREQW_UPDATE;
    end
  end

  task automatic new_test(input int period, input int ticks_per_done);
    tick_cnt = 0; done_cnt = 0; last_done_tick = 0;
    tpd = ticks_per_done; exp_period = period; last_req_cyc = -1;
  endtask

  // Called at a negedge; returns at the negedge after the START edge.
  task automatic do_start(input logic m, input logic [31:0] b, input logic [31:0] s,
                          input logic [IDX_W-1:0] n, input logic [DWELL_W-1:0] d);
    MODE = m; BASE_FREQW = b; STEP_FREQW = s; STEP_NUM = n; DWELL = d;
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
  endtask

  task automatic wait_req(input int budget, input string tag);
    int n = 0;
    @(negedge CLK);
    while (!FREQW_UPDATE && n < budget) begin @(negedge CLK); n++; end
    chk(tag, {31'd0, FREQW_UPDATE}, 32'd1);
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n = 0;
    @(negedge CLK);
    while (BUSY && n < budget) begin @(negedge CLK); n++; end
    chk(tag, {31'd0, BUSY}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=time_limit expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic any;
    int n;
    RESET = 1'b1; START = 1'b0; ABORT = 1'b0; MODE = 1'b0; INIT_OK = 1'b1;
    BASE_FREQW = '0; STEP_FREQW = '0; STEP_NUM = '0; DWELL = '0;
    new_test(0, 1);
    repeat (3) @(negedge CLK);
    chk("rst_freqw", FREQW, 32'd0);
    chk("rst_flags", {11'd0, STEP_IDX, FREQW_UPDATE, BUSY, STEP_TICK, SWEEP_DONE, TIMEOUT_ERR}, 32'd0);
    RESET = 1'b0;
    @(negedge CLK);

    // 1: single sweep, four points
    ack_lat = 4;
    new_test(17, 4);
    exp_fw.push_back(32'h1000_0000); exp_fw.push_back(32'h1100_0000);
    exp_fw.push_back(32'h1200_0000); exp_fw.push_back(32'h1300_0000);
    for (int i = 0; i < 4; i++) exp_idx.push_back(IDX_W'(i));
    do_start(1'b0, 32'h1000_0000, 32'h0100_0000, 16'd3, 24'd10);
    chk("t1_busy", {31'd0, BUSY}, 32'd1);
    chk("t1_no_req_yet", {31'd0, FREQW_UPDATE}, 32'd0);
    @(negedge CLK);
    chk("t1_start_latency", {31'd0, FREQW_UPDATE}, 32'd1);
    wait_idle(200, "t1_idle");
    chk("t1_ticks", 32'(tick_cnt), 32'd4);
    chk("t1_done", 32'(done_cnt), 32'd1);
    chk("t1_fw_left", 32'(exp_fw.size()), 32'd0);
    chk("t1_idx_hold", 32'(STEP_IDX), 32'd3);
    chk("t1_freqw_hold", FREQW, 32'h1300_0000);

    // 2: 32-bit wrap of the accumulator
    new_test(0, 2);
    exp_fw.push_back(32'hFFFF_FF00); exp_fw.push_back(32'h0000_0100);
    exp_idx.push_back(0); exp_idx.push_back(1);
    do_start(1'b0, 32'hFFFF_FF00, 32'h0000_0200, 16'd1, 24'd2);
    wait_idle(100, "t2_idle");
    chk("t2_done", 32'(done_cnt), 32'd1);
    chk("t2_fw_left", 32'(exp_fw.size()), 32'd0);

    // 3: continuous, DWELL=0 acts as 1, abort in DWELL
    new_test(8, 2);
    for (int i = 0; i < 5; i++) begin
      exp_fw.push_back((i % 2 == 0) ? 32'h0500_0000 : 32'h0500_0040);
      exp_idx.push_back(IDX_W'(i % 2));
    end
    do_start(1'b1, 32'h0500_0000, 32'h0000_0040, 16'd1, 24'd0);
    n = 0;
    @(negedge CLK); #1;
    while (tick_cnt < 5 && n < 200) begin @(negedge CLK); #1; n++; end
    chk("t3_fifth_tick", 32'(tick_cnt), 32'd5);
    ABORT = 1'b1;
    @(negedge CLK);
    ABORT = 1'b0;
    chk("t3_abort_idle", {31'd0, BUSY}, 32'd0);
    repeat (20) @(negedge CLK);
    chk("t3_done", 32'(done_cnt), 32'd2);
    chk("t3_fw_left", 32'(exp_fw.size()), 32'd0);

    // 4: abort during GUARD -> DRAIN, START during DRAIN ignored
    ack_lat = 20;
    new_test(0, 1);
    exp_fw.push_back(32'h0777_0000);
    do_start(1'b0, 32'h0777_0000, 32'h1, 16'd2, 24'd4);
    wait_req(10, "t4_req");
    @(negedge CLK);
    ABORT = 1'b1;
    @(negedge CLK);
    ABORT = 1'b0;
    do_start(1'b0, 32'h0888_0000, 32'h1, 16'd0, 24'd4);
    n = 0;
    while (!FREQW_UPDATE_OVER && n < 100) begin
      chk("t4_busy_drain", {31'd0, BUSY}, 32'd1);
      @(negedge CLK); n++;
    end
    chk("t4_ack_seen", {31'd0, FREQW_UPDATE_OVER}, 32'd1);
    chk("t4_busy_at_ack", {31'd0, BUSY}, 32'd1);
    @(negedge CLK);
    chk("t4_idle_after_ack", {31'd0, BUSY}, 32'd0);
    any = 1'b0;
    repeat (30) begin @(negedge CLK); any |= BUSY; end
    chk("t4_start_ignored", {31'd0, any}, 32'd0);
    chk("t4_ticks", 32'(tick_cnt), 32'd0);

    // 5: INIT_OK held low for 50 cycles; single point (STEP_NUM=0)
    ack_lat = 4;
    new_test(0, 1);
    INIT_OK = 1'b0;
    exp_fw.push_back(32'h0ABC_0000); exp_idx.push_back(0);
    do_start(1'b0, 32'h0ABC_0000, 32'h10, 16'd0, 24'd3);
    any = 1'b0;
    repeat (50) begin @(negedge CLK); any |= FREQW_UPDATE; end
    chk("t5_no_req_before_init", {31'd0, any}, 32'd0);
    INIT_OK = 1'b1;
    @(negedge CLK);
    chk("t5_req_after_init", {31'd0, FREQW_UPDATE}, 32'd1);
    wait_idle(100, "t5_idle");
    chk("t5_ticks", 32'(tick_cnt), 32'd1);
    chk("t5_done", 32'(done_cnt), 32'd1);

    // 6: no acknowledge -> timeout after 64 WAIT_ACK cycles
    ack_lat = 0;
    new_test(0, 1);
    exp_fw.push_back(32'h2222_0000);
    do_start(1'b0, 32'h2222_0000, 32'h1, 16'd0, 24'd5);
    wait_req(10, "t6_req");
    repeat (66) @(negedge CLK);
    chk("t6_no_err_yet", {30'd0, TIMEOUT_ERR, BUSY}, 32'd1);
    @(negedge CLK);
    chk("t6_err_set", {30'd0, TIMEOUT_ERR, BUSY}, 32'd2);
    repeat (5) @(negedge CLK);
    chk("t6_err_sticky", {31'd0, TIMEOUT_ERR}, 32'd1);
    ack_lat = 4;
    exp_fw.push_back(32'h3333_0000); exp_idx.push_back(0);
    do_start(1'b0, 32'h3333_0000, 32'h1, 16'd0, 24'd2);
    chk("t6_err_cleared", {31'd0, TIMEOUT_ERR}, 32'd0);
    wait_idle(100, "t6_idle");

    // 7: asynchronous reset mid-sweep
    new_test(0, 2);
    exp_fw.push_back(32'h4444_0000); exp_fw.push_back(32'h4444_1000);
    exp_idx.push_back(0); exp_idx.push_back(1);
    do_start(1'b1, 32'h4444_0000, 32'h1000, 16'd1, 24'd6);
    n = 0;
    while (!STEP_TICK && n < 50) begin @(negedge CLK); n++; end
    chk("t7_tick", {31'd0, STEP_TICK}, 32'd1);
    #2 RESET = 1'b1;
    #1;
    chk("t7_async_clear", {11'd0, STEP_IDX, FREQW_UPDATE, BUSY, STEP_TICK, SWEEP_DONE, TIMEOUT_ERR}, 32'd0);
    chk("t7_async_freqw", FREQW, 32'd0);
    exp_fw.delete(); exp_idx.delete();
    @(negedge CLK);
    RESET = 1'b0;
    any = 1'b0;
    repeat (20) begin @(negedge CLK); any |= FREQW_UPDATE | BUSY; end
    chk("t7_quiet", {31'd0, any}, 32'd0);

    repeat (3) @(negedge CLK);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
